// File: rtl/bpu_pkg.sv
// Shared types for the branch resolve controller: default predictor index width,
// in-flight entry layout, recovery FSM states and a saturating counter helper.
// Pure declarations; no timing or flow control of its own.
package bpu_pkg;

  // Default predictor index width.
  localparam int PC_W_DEF = 8;

  // One in-flight branch: predictor index plus the prediction given at fetch.
  // The queue stores entries in this bit order ({pc, pred}, pred in bit 0).
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                pred;
  } entry_t;

  // Controller state: normal operation, or the one-cycle bubble after a mispredict.
  typedef enum logic {
    ACTIVE  = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/branch_queue_fifo.sv
// In-order storage for in-flight branches: push at tail, pop at head, bulk clear.
// Latency: head_data is combinational from the head pointer; count updates next edge.
// Backpressure: pushes while full and pops while empty are ignored; clear beats both.
module branch_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    tail_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the current fill level; a clear squashes both.
  always_comb begin
    do_push = push && (count != FULL_CNT) && !clear;
    do_pop  = pop && (count != '0) && !clear;
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + AW'(1);
      if (do_pop)  head_ptr <= head_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Oldest entry is always visible for the resolve comparison.
  assign head_data = mem[head_ptr];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted conditional branches in fetch order, retires them on resolve and
// emits predictor updates / mispredict pulses one cycle after the resolve (registered).
// Backpressure: alloc_ready drops when the queue is full, in the recovery cycle and in reset.
// Optional build macro BRC_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_ctrl
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic                     alloc_pred,
  output logic                     alloc_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     upd_branch,
  output logic                     upd_taken,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mis_pc,
`ifdef BRC_STATS_EN
  output logic [15:0]              stat_branches,
  output logic [15:0]              stat_mispredicts,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W:0]   head_data;
  logic [PC_W-1:0] head_pc;
  logic            head_pred;
  logic            res_acc;
  logic            res_mis;
  logic            alloc_acc;
  logic            q_push;
  logic            q_pop;
  logic            q_clear;

  // Head entry fields, same {pc, pred} layout as entry_t.
  assign head_pc   = head_data[PC_W:1];
  assign head_pred = head_data[0];

  // Request qualification in priority order: flush > resolve > alloc.
  always_comb begin
    alloc_ready = !reset && (occupancy < FULL_OCC) && (state == ACTIVE);
    res_acc     = resolve_valid && (occupancy != '0) && !flush;
    res_mis     = res_acc && (head_pred != resolve_taken);
    alloc_acc   = alloc_valid && alloc_ready && !flush && !res_mis;
    q_push      = alloc_acc;
    q_pop       = res_acc && !res_mis;
    q_clear     = flush || res_mis;
  end

  branch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + 1)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({alloc_pc, alloc_pred}),
    .pop       (q_pop),
    .clear     (q_clear),
    .head_data (head_data),
    .count     (occupancy)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACTIVE;
    else       state <= state_nxt;
  end

  // Next state: a mispredict buys exactly one recovery cycle; flush forces ACTIVE.
  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (res_mis) state_nxt = RECOVER;
      RECOVER: state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
    if (flush) state_nxt = ACTIVE;
  end

  // Registered predictor update and mispredict report, one cycle after the resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_branch <= 1'b0;
      upd_taken  <= 1'b0;
      upd_pc     <= '0;
      mispredict <= 1'b0;
      mis_pc     <= '0;
    end else begin
      upd_branch <= res_acc;
      mispredict <= res_mis;
      if (res_acc) begin
        upd_taken <= resolve_taken;
        upd_pc    <= head_pc;
      end
      if (res_mis) mis_pc <= head_pc;
    end
  end

`ifdef BRC_STATS_EN
  // Saturating counts of accepted resolves and mispredicts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_acc) stat_branches    <= sat_inc(stat_branches);
      if (res_mis) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: a queue model predicts each cycle's
// update/mispredict, the expectation is scoreboarded and compared one edge later.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_branch_resolve_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic [7:0] alloc_pc;
  logic       alloc_pred;
  logic       alloc_ready;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       flush;
  logic       upd_branch;
  logic       upd_taken;
  logic [7:0] upd_pc;
  logic       mispredict;
  logic [7:0] mis_pc;
  logic [2:0] occupancy;
`ifdef BRC_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
  int          m_branches = 0;
  int          m_mispredicts = 0;
`endif

  typedef struct {
    logic [7:0] pc;
    logic       taken;
    logic       mis;
  } exp_t;

  typedef struct {
    logic [7:0] pc;
    logic       pred;
  } ent_t;

  exp_t sb[$];
  ent_t mq[$];
  bit   mrec = 1'b0;
  int   checks = 0;
  int   errors = 0;

  branch_resolve_ctrl #(.DEPTH(4), .PC_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_pc         (alloc_pc),
    .alloc_pred       (alloc_pred),
    .alloc_ready      (alloc_ready),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .upd_branch       (upd_branch),
    .upd_taken        (upd_taken),
    .upd_pc           (upd_pc),
    .mispredict       (mispredict),
    .mis_pc           (mis_pc),
`ifdef BRC_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  // One clock: model the cycle from the current inputs, then compare after the edge.
  task automatic tick();
    bit   ready;
    bit   res;
    bit   mis;
    ent_t e;
    exp_t x;
    ready = (mq.size() < 4) && !mrec;
    checks++;
    if (alloc_ready !== ready) begin
      errors++;
      $display("FAIL alloc_ready: got %b expected %b at %0t", alloc_ready, ready, $time);
    end
    if (flush) begin
      mq.delete();
      mrec = 1'b0;
    end else begin
      res = resolve_valid && (mq.size() != 0);
      mis = 1'b0;
      if (res) begin
        e       = mq[0];
        mis     = (e.pred !== resolve_taken);
        x.pc    = e.pc;
        x.taken = resolve_taken;
        x.mis   = mis;
        sb.push_back(x);
`ifdef BRC_STATS_EN
        m_branches++;
        if (mis) m_mispredicts++;
`endif
        if (mis) mq.delete();
        else void'(mq.pop_front());
      end
      if (alloc_valid && ready && !mis) begin
        e.pc   = alloc_pc;
        e.pred = alloc_pred;
        mq.push_back(e);
      end
      mrec = mis;
    end
    @(posedge clk);
    #1;
    checks++;
    if (upd_branch === 1'b1) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: upd_branch=1 upd_pc=%h with nothing expected", upd_pc);
      end else begin
        x = sb.pop_front();
        if (upd_pc !== x.pc || upd_taken !== x.taken || mispredict !== x.mis ||
            (x.mis && mis_pc !== x.pc)) begin
          errors++;
          $display("FAIL sb_update: got pc=%h taken=%b mis=%b mis_pc=%h expected pc=%h taken=%b mis=%b",
                   upd_pc, upd_taken, mispredict, mis_pc, x.pc, x.taken, x.mis);
        end
      end
    end else if (sb.size() != 0 || mispredict !== 1'b0 || upd_branch !== 1'b0) begin
      errors++;
      $display("FAIL sb_missing: got upd_branch=%b mispredict=%b expected %0d pending update(s)",
               upd_branch, mispredict, sb.size());
      sb.delete();
    end
    checks++;
    if (occupancy !== 3'(mq.size())) begin
      errors++;
      $display("FAIL occupancy: got %0d expected %0d", occupancy, mq.size());
    end
  endtask

  task automatic drive(input bit av, input logic [7:0] pc, input bit pr,
                       input bit rv, input bit rt, input bit fl);
    alloc_valid   = av;
    alloc_pc      = pc;
    alloc_pred    = pr;
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (upd_branch !== 1'b0 || upd_taken !== 1'b0 || upd_pc !== 8'h00 || mispredict !== 1'b0 ||
        mis_pc !== 8'h00 || occupancy !== 3'd0 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got upd=%b tk=%b pc=%h mis=%b mpc=%h occ=%0d rdy=%b expected all 0",
               name, upd_branch, upd_taken, upd_pc, mispredict, mis_pc, occupancy, alloc_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alloc_valid = 1'b0; alloc_pc = 8'h00; alloc_pred = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    #2;
    check_all_zero("reset_state");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", alloc_ready);
    end
  endtask

  task automatic test_in_order();
    drive(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (upd_branch !== 1'b1 || upd_pc !== 8'h10 || upd_taken !== 1'b1 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL in_order: got upd=%b pc=%h tk=%b mis=%b expected 1 10 1 0",
               upd_branch, upd_pc, upd_taken, mispredict);
    end
    idle();
  endtask

  task automatic test_mispredict();
    drive(1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h28, 1'b1, 1'b0, 1'b0, 1'b0);
    // Same-cycle allocation must be dropped by the mispredict.
    drive(1'b1, 8'h2C, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mispredict !== 1'b1 || mis_pc !== 8'h20 || occupancy !== 3'd0 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL mispredict: got mis=%b mis_pc=%h occ=%0d rdy=%b expected 1 20 0 0",
               mispredict, mis_pc, occupancy, alloc_ready);
    end
    idle();
    checks++;
    if (alloc_ready !== 1'b1 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL recover_exit: got rdy=%b mis=%b expected 1 0", alloc_ready, mispredict);
    end
  endtask

  task automatic test_full();
    drive(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h38, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 3'd4 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: got occ=%0d rdy=%b expected 4 0", occupancy, alloc_ready);
    end
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (occupancy !== 3'd3 || upd_pc !== 8'h30) begin
      errors++;
      $display("FAIL full_no_bypass: got occ=%0d upd_pc=%h expected 3 30", occupancy, upd_pc);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_flush_vs_resolve();
    drive(1'b1, 8'h60, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h68, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (upd_branch !== 1'b0 || mispredict !== 1'b0 || occupancy !== 3'd0 || alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: got upd=%b mis=%b occ=%0d rdy=%b expected 0 0 0 1",
               upd_branch, mispredict, occupancy, alloc_ready);
    end
    idle();
  endtask

  task automatic test_empty_resolve();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (upd_branch !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL empty_resolve: got upd=%b occ=%0d expected 0 0", upd_branch, occupancy);
    end
    drive(1'b1, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (upd_branch !== 1'b0 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL empty_resolve_alloc: got upd=%b occ=%0d expected 0 1", upd_branch, occupancy);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_wrap();
    logic [7:0] pc_i;
    drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      pc_i = 8'h40 + 8'(i);
      drive(i < 10, pc_i, pc_i[0], 1'b1, pc_i[0] ^ 1'b1, 1'b0);
      checks++;
      if (upd_branch !== 1'b1 || upd_pc !== pc_i - 8'd1 || mispredict !== 1'b0 ||
          occupancy !== ((i < 10) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL wrap_%0d: got upd=%b pc=%h mis=%b occ=%0d expected 1 %h 0 %0d",
                 i, upd_branch, upd_pc, mispredict, occupancy, pc_i - 8'd1, (i < 10) ? 1 : 0);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h74, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 1'b0);
    alloc_valid = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    alloc_pc = 8'h00; alloc_pred = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("reset_async");
    mq.delete();
    sb.delete();
    mrec = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    reset = 1'b0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", alloc_ready);
    end
    drive(1'b1, 8'h7C, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_mispredict();
    test_full();
    test_flush_vs_resolve();
    test_empty_resolve();
    test_wrap();
`ifdef BRC_STATS_EN
    checks++;
    if (stat_branches !== 16'(m_branches) || stat_mispredicts !== 16'(m_mispredicts)) begin
      errors++;
      $display("FAIL stats: got %0d/%0d expected %0d/%0d",
               stat_branches, stat_mispredicts, m_branches, m_mispredicts);
    end
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the in-flight branch queue depth (power of 2, >=2).
REQ-002 The block SHALL have parameter PC_W, default 8, giving the predictor index width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have clk  in  1  rising-edge clock.
REQ-005 The block SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have alloc_valid  in  1  fetch issued a predicted conditional branch.
REQ-007 The block SHALL have alloc_pc  in  PC_W  predictor index of that branch.
REQ-008 The block SHALL have alloc_pred  in  1  prediction given (1 = taken).
REQ-009 The block SHALL have alloc_ready  out  1  queue can accept an allocation this cycle.
REQ-010 The block SHALL have resolve_valid  in  1  execute resolved the oldest in-flight branch.
REQ-011 The block SHALL have resolve_taken  in  1  actual outcome.
REQ-012 The block SHALL have flush  in  1  external squash (exception/interrupt).
REQ-013 The block SHALL have upd_branch, upd_taken  out  1 each  predictor update strobe and outcome.
REQ-014 The block SHALL have upd_pc  out  PC_W  predictor index to update.
REQ-015 The block SHALL have mispredict  out  1  one-cycle pulse, wrong prediction.
REQ-016 The block SHALL have mis_pc  out  PC_W  index of the mispredicted branch.
REQ-017 The block SHALL have occupancy  out  $clog2(DEPTH)+1  entries in flight.

Function
REQ-018 Allocation SHALL occur when alloc_valid && alloc_ready; the entry {alloc_pc, alloc_pred} is pushed at the tail.
REQ-019 alloc_ready SHALL be (occupancy < DEPTH) && state == ACTIVE, with no same-cycle bypass from a resolve when full.
REQ-020 Resolve SHALL pop the head entry only when resolve_valid && occupancy != 0; a resolve while empty is ignored, including when an allocation happens in the same cycle.
REQ-021 Simultaneous accepted alloc and resolve SHALL leave occupancy unchanged.
REQ-022 Each accepted resolve SHALL drive upd_branch=1, upd_pc=head pc and upd_taken=resolve_taken, registered, exactly one cycle later; upd_branch is otherwise 0.
REQ-023 If the head prediction != resolve_taken, the block SHALL pulse mispredict with mis_pc=head pc, together with the update, and clear the queue, squashing all younger entries.
REQ-024 An allocation in the same cycle as a mispredicting resolve SHALL be dropped.
REQ-025 The FSM SHALL have states ACTIVE and RECOVER: ACTIVE->RECOVER on a mispredicting resolve; RECOVER->ACTIVE after exactly one cycle; alloc_ready=0 in RECOVER.
REQ-026 flush SHALL clear the queue next edge, produce no update or mispredict, and override any same-cycle resolve or allocation; the FSM stays in or returns to ACTIVE.
REQ-027 Priority SHALL be reset > flush > resolve > alloc.
REQ-028 Head and tail pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 On reset the block SHALL immediately set occupancy=0, pointers=0, state=ACTIVE, upd_branch=0, upd_taken=0, upd_pc=0, mispredict=0 and mis_pc=0, with alloc_ready=1 once reset is deasserted.
REQ-030 A reset mid-operation SHALL discard all in-flight entries and any pending update.

Configuration
REQ-031 With BRC_STATS_EN defined, the block SHALL add outputs stat_branches[15:0] and stat_mispredicts[15:0], which count accepted resolves and mispredicts, saturate at 16'hFFFF, and clear on reset.
REQ-032 Without BRC_STATS_EN, these ports and counters SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-033 Package bpu_pkg SHALL hold PC_W default, the entry typedef {pc, pred} and the state enum {ACTIVE, RECOVER}.
REQ-034 Entry storage and pointers SHALL be one sub-module, branch_queue_fifo (push, pop, clear, count).

Verification
REQ-035 The bench SHALL cover in-order resolve: alloc pc=8'h10 pred=1, then resolve taken=1 -> next cycle upd_branch=1, upd_pc=8'h10, upd_taken=1, mispredict=0.
REQ-036 The bench SHALL cover mispredict squash: alloc 8'h20/1, 8'h24/0, 8'h28/1; resolve taken=0 -> mispredict=1, mis_pc=8'h20, occupancy=0, alloc_ready=0 for one cycle, then 1.
REQ-037 The bench SHALL cover full: 4 allocs -> alloc_ready=0; a 5th alloc with a simultaneous resolve is not accepted, and occupancy=3.
REQ-038 The bench SHALL cover flush versus resolve: 2 entries, flush and resolve in the same cycle -> no upd_branch, occupancy=0.
REQ-039 The bench SHALL cover empty resolve: resolve_valid=1 with an empty queue, with and without a same-cycle alloc -> no update, occupancy 0 or 1 respectively.
REQ-040 The bench SHALL cover wrap and reset: 10 alloc/resolve pairs -> correct upd_pc sequence; assert reset mid-stream -> all outputs 0 asynchronously.
